// File: rtl/parking_slot_arbiter_pkg.sv
// Shared types and constants for the parking slot arbiter.
//   - FSM state encoding, entry result codes, arbitration winner codes
//   - latched-operand payload struct and the CAP default
package parking_slot_arbiter_pkg;

    localparam int unsigned CAP_DEFAULT = 5;
    localparam int unsigned FREE_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECIDE    = 2'd1,
        ST_ACK       = 2'd2,
        ST_WAIT_DROP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'b00,
        RES_CHOSEN = 2'b01,
        RES_ALT    = 2'b10,
        RES_FULL   = 2'b11
    } ent_result_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_ADM  = 2'd1,
        WIN_ENT  = 2'd2,
        WIN_EXT  = 2'd3
    } winner_e;

    // Encoding of the round-robin last_served bit
    localparam logic SERVED_ENT = 1'b0;
    localparam logic SERVED_EXT = 1'b1;

    // Operands captured when a request wins arbitration
    typedef struct packed {
        winner_e             kind;
        logic                flr;
        logic                special;
        logic [FREE_W-1:0]   count;
    } op_t;

    // Limit a requested free-slot count to the floor capacity
    function automatic logic [FREE_W-1:0] clamp_cap(input logic [FREE_W-1:0] value,
                                                     input logic [FREE_W-1:0] cap);
        return (value > cap) ? cap : value;
    endfunction

endpackage

// File: rtl/parking_rr_picker.sv
// Combinational request picker: admin always wins; entry vs exit is
// round-robin, granting whichever was not served last.
//   adm_req, ent_req, ext_req : pending requests
//   last_served               : SERVED_ENT / SERVED_EXT
//   winner_c                  : selected requester (WIN_NONE if none)
module parking_rr_picker
    import parking_slot_arbiter_pkg::*;
(
    input  logic    adm_req,
    input  logic    ent_req,
    input  logic    ext_req,
    input  logic    last_served,
    output winner_e winner_c
);

    always_comb begin
        winner_c = WIN_NONE;
        if (adm_req) begin
            winner_c = WIN_ADM;
        end else if (ent_req && ext_req) begin
            winner_c = (last_served == SERVED_EXT) ? WIN_ENT : WIN_EXT;
        end else if (ent_req) begin
            winner_c = WIN_ENT;
        end else if (ext_req) begin
            winner_c = WIN_EXT;
        end
    end

endmodule

// File: rtl/parking_slot_arbiter.sv
// Two-floor parking slot arbiter. Serves one entry/exit/admin request at a
// time: IDLE picks and latches, DECIDE computes, ACK pulses, WAIT_DROP
// waits for the winner to release its request.
//   clk, reset                         : clock, synchronous active-high reset
//   ent_req/ent_flr/ent_special        : entry request and operands
//   ext_req/ext_flr                    : exit request and operand
//   adm_req/adm_flr/adm_count          : admin overwrite request and operands
//   ent_ack/ent_result/ent_flr_granted : entry completion
//   ext_ack/ext_err                    : exit completion
//   adm_ack                            : admin completion
//   free0, free1                       : free slots per floor
//   busy                               : FSM not in IDLE
module parking_slot_arbiter
    import parking_slot_arbiter_pkg::*;
#(
    parameter int unsigned CAP         = CAP_DEFAULT,
    parameter int unsigned SPECIAL_FLR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ent_req,
    input  logic              ent_flr,
    input  logic              ent_special,
    input  logic              ext_req,
    input  logic              ext_flr,
    input  logic              adm_req,
    input  logic              adm_flr,
    input  logic [FREE_W-1:0] adm_count,
    output logic              ent_ack,
    output logic [1:0]        ent_result,
    output logic              ent_flr_granted,
    output logic              ext_ack,
    output logic              ext_err,
    output logic              adm_ack,
    output logic [FREE_W-1:0] free0,
    output logic [FREE_W-1:0] free1,
    output logic              busy
);

    localparam logic [FREE_W-1:0] CAP_V   = FREE_W'(CAP);
    localparam logic              SPC_FLR = 1'(SPECIAL_FLR);

    state_e            state_q, state_n;
    op_t               op_q, op_n;
    logic              last_served_q, last_served_n;
    winner_e           winner_c;

    logic [FREE_W-1:0] free0_n, free1_n;
    logic              ent_ack_n, ent_flr_granted_n, ext_ack_n, ext_err_n, adm_ack_n, busy_n;
    ent_result_e       ent_result_n;

    logic [FREE_W-1:0] sel_free, oth_free, spc_free;
    logic              win_req_held;
    logic              upd_en, upd_flr;
    logic [FREE_W-1:0] upd_val;

    parking_rr_picker u_picker (
        .adm_req     (adm_req),
        .ent_req     (ent_req),
        .ext_req     (ext_req),
        .last_served (last_served_q),
        .winner_c    (winner_c)
    );

    // Counter views relative to the latched floor and the special floor
    assign sel_free = op_q.flr ? free1 : free0;
    assign oth_free = op_q.flr ? free0 : free1;
    assign spc_free = SPC_FLR  ? free1 : free0;

    // Whether the current winner is still holding its request
    always_comb begin
        win_req_held = 1'b0;
        case (op_q.kind)
            WIN_ADM: win_req_held = adm_req;
            WIN_ENT: win_req_held = ent_req;
            WIN_EXT: win_req_held = ext_req;
            default: win_req_held = 1'b0;
        endcase
    end

    // Next-state, operand latch, result and counter computation
    always_comb begin
        state_n           = state_q;
        op_n              = op_q;
        last_served_n     = last_served_q;
        free0_n           = free0;
        free1_n           = free1;
        ent_ack_n         = 1'b0;
        ent_result_n      = RES_NONE;
        ent_flr_granted_n = 1'b0;
        ext_ack_n         = 1'b0;
        ext_err_n         = 1'b0;
        adm_ack_n         = 1'b0;
        upd_en            = 1'b0;
        upd_flr           = 1'b0;
        upd_val           = '0;

        case (state_q)
            ST_IDLE: begin
                if (winner_c != WIN_NONE) begin
                    op_n.kind    = winner_c;
                    op_n.flr     = (winner_c == WIN_ADM) ? adm_flr :
                                   (winner_c == WIN_ENT) ? ent_flr : ext_flr;
                    op_n.special = ent_special;
                    op_n.count   = adm_count;
                    state_n      = ST_DECIDE;
                end
            end

            ST_DECIDE: begin
                state_n = ST_ACK;
                case (op_q.kind)
                    WIN_ENT: begin
                        ent_ack_n = 1'b1;
                        if (op_q.special) begin
                            if (spc_free != '0) begin
                                ent_result_n      = RES_CHOSEN;
                                ent_flr_granted_n = SPC_FLR;
                                upd_en            = 1'b1;
                                upd_flr           = SPC_FLR;
                                upd_val           = spc_free - FREE_W'(1);
                            end else begin
                                ent_result_n = RES_FULL;
                            end
                        end else if (sel_free != '0) begin
                            ent_result_n      = RES_CHOSEN;
                            ent_flr_granted_n = op_q.flr;
                            upd_en            = 1'b1;
                            upd_flr           = op_q.flr;
                            upd_val           = sel_free - FREE_W'(1);
                        end else if (oth_free != '0) begin
                            ent_result_n      = RES_ALT;
                            ent_flr_granted_n = ~op_q.flr;
                            upd_en            = 1'b1;
                            upd_flr           = ~op_q.flr;
                            upd_val           = oth_free - FREE_W'(1);
                        end else begin
                            ent_result_n = RES_FULL;
                        end
                    end
                    WIN_EXT: begin
                        ext_ack_n = 1'b1;
                        if (sel_free < CAP_V) begin
                            upd_en  = 1'b1;
                            upd_flr = op_q.flr;
                            upd_val = sel_free + FREE_W'(1);
                        end else begin
                            ext_err_n = 1'b1;
                        end
                    end
                    WIN_ADM: begin
                        adm_ack_n = 1'b1;
                        upd_en    = 1'b1;
                        upd_flr   = op_q.flr;
                        upd_val   = clamp_cap(op_q.count, CAP_V);
                    end
                    default: state_n = ST_IDLE;
                endcase
            end

            ST_ACK: begin
                state_n = ST_WAIT_DROP;
                if (op_q.kind == WIN_ENT) begin
                    last_served_n = SERVED_ENT;
                end else if (op_q.kind == WIN_EXT) begin
                    last_served_n = SERVED_EXT;
                end
            end

            ST_WAIT_DROP: begin
                if (!win_req_held) begin
                    state_n = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase

        if (upd_en) begin
            if (upd_flr) begin
                free1_n = upd_val;
            end else begin
                free0_n = upd_val;
            end
        end

        busy_n = (state_n != ST_IDLE);
    end

    // State and registered outputs; counters change together with the ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            op_q            <= '0;
            last_served_q   <= SERVED_EXT;
            free0           <= CAP_V;
            free1           <= CAP_V;
            ent_ack         <= 1'b0;
            ent_result      <= RES_NONE;
            ent_flr_granted <= 1'b0;
            ext_ack         <= 1'b0;
            ext_err         <= 1'b0;
            adm_ack         <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_n;
            op_q            <= op_n;
            last_served_q   <= last_served_n;
            free0           <= free0_n;
            free1           <= free1_n;
            ent_ack         <= ent_ack_n;
            ent_result      <= ent_result_n;
            ent_flr_granted <= ent_flr_granted_n;
            ext_ack         <= ext_ack_n;
            ext_err         <= ext_err_n;
            adm_ack         <= adm_ack_n;
            busy            <= busy_n;
        end
    end

endmodule
